// File: rtl/mem_copy_dma.sv
// Block-transfer initiator for the single-port program/data RAM:
// copies an ascending word range or fills a range with a constant pattern.
module mem_copy_dma #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              fill,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W:0]   length,
  input  logic [DATA_W-1:0] pattern,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] src_ptr_q, src_ptr_d;
  logic [ADDR_W-1:0] dst_ptr_q, dst_ptr_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] buf_q, buf_d;
  logic              mode_q, mode_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      src_ptr_q <= '0;
      dst_ptr_q <= '0;
      cnt_q     <= '0;
      buf_q     <= '0;
      mode_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_ptr_q <= src_ptr_d;
      dst_ptr_q <= dst_ptr_d;
      cnt_q     <= cnt_d;
      buf_q     <= buf_d;
      mode_q    <= mode_d;
    end
  end

  // Pointer increments wrap naturally at the top of the address space.
  always_comb begin
    state_d   = state_q;
    src_ptr_d = src_ptr_q;
    dst_ptr_d = dst_ptr_q;
    cnt_d     = cnt_q;
    buf_d     = buf_q;
    mode_d    = mode_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          src_ptr_d = src_addr;
          dst_ptr_d = dst_addr;
          cnt_d     = length;
          mode_d    = fill;
          if (fill) begin
            buf_d = pattern;
          end
          if (length == '0) begin
            state_d = S_DONE;
          end else if (fill) begin
            state_d = S_WRITE;
          end else begin
            state_d = S_READ;
          end
        end
      end
      S_READ: begin
        buf_d     = mem_rdata;
        src_ptr_d = src_ptr_q + ADDR_W'(1);
        state_d   = S_WRITE;
      end
      S_WRITE: begin
        dst_ptr_d = dst_ptr_q + ADDR_W'(1);
        cnt_d     = cnt_q - (ADDR_W + 1)'(1);
        if (cnt_q == (ADDR_W + 1)'(1)) begin
          state_d = S_DONE;
        end else if (mode_q) begin
          state_d = S_WRITE;
        end else begin
          state_d = S_READ;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    case (state_q)
      S_READ: begin
        busy     = 1'b1;
        mem_addr = src_ptr_q;
      end
      S_WRITE: begin
        busy      = 1'b1;
        mem_addr  = dst_ptr_q;
        mem_we    = 1'b1;
        mem_wdata = buf_q;
      end
      S_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_copy_dma.sv
// Directed bench for mem_copy_dma: a behavioural 4096x16 RAM with combinational
// read, a table of transfers with hand-computed results, plus a reset sequence.
`timescale 1ns/1ps
module tb_mem_copy_dma;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        fill = 1'b0;
  logic [11:0] src_addr = '0;
  logic [11:0] dst_addr = '0;
  logic [12:0] length = '0;
  logic [15:0] pattern = '0;
  logic        busy, done, mem_we;
  logic [11:0] mem_addr;
  logic [15:0] mem_wdata, mem_rdata;

  logic [15:0] ram [4096];
  logic        pre_we = 1'b0;
  logic [11:0] pre_a = '0;
  logic [15:0] pre_d = '0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_copy_dma #(.ADDR_W(12), .DATA_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .fill(fill),
    .src_addr(src_addr), .dst_addr(dst_addr), .length(length), .pattern(pattern),
    .busy(busy), .done(done), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    else if (pre_we) ram[pre_a] <= pre_d;
  end
  assign mem_rdata = ram[mem_addr];

  typedef struct packed {
    bit              fill;
    logic [11:0]     src;
    logic [11:0]     dst;
    logic [12:0]     len;
    logic [15:0]     pat;
    int              pre_n;
    logic [11:0]     pre_a;
    logic [3:0][15:0] pre_d;
    int              poke;
    int              exp_k;
    int              exp_we;
    int              chk_n;
    logic [3:0][11:0] chk_a;
    logic [3:0][15:0] chk_d;
  } vec_t;

  vec_t vecs [7];
  vec_t post;

  task automatic check(input string nm, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic ram_wr(input logic [11:0] a, input logic [15:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_a = a; pre_d = d;
    @(posedge clk);
    #1 pre_we = 1'b0;
  endtask

  task automatic apply_vec(input vec_t v, input string nm);
    int  k;
    int  we;
    bit  got;
    logic [11:0] a;
    for (int i = 0; i < v.pre_n; i++) begin
      a = v.pre_a + 12'(i);
      ram_wr(a, v.pre_d[i]);
    end
    @(negedge clk);
    start = 1'b1; fill = v.fill; src_addr = v.src; dst_addr = v.dst;
    length = v.len; pattern = v.pat;
    @(posedge clk);
    #1 start = 1'b0;
    k = 0; we = 0; got = 1'b0;
    while (!got && k <= 200) begin
      if (done) begin
        got = 1'b1;
      end else begin
        @(negedge clk);
        if (k == v.poke) begin
          start = 1'b1; fill = 1'b1; dst_addr = 12'h600; length = 13'd1; pattern = 16'hDEAD;
        end
        if (mem_we) we++;
        @(posedge clk);
        #1 start = 1'b0;
        k++;
      end
    end
    check({nm, " done_latency"}, got ? k : -1, v.exp_k);
    check({nm, " we_count"}, we, v.exp_we);
    if (got) begin
      check({nm, " busy_in_done"}, int'(busy), 1);
      @(posedge clk);
      #1;
      check({nm, " done_one_cycle"}, int'(done), 0);
      check({nm, " busy_drop"}, int'(busy), 0);
    end
    if (v.poke >= 0) begin
      @(posedge clk);
      #1 check({nm, " start_not_queued"}, int'(busy), 0);
    end
    for (int i = 0; i < v.chk_n; i++) begin
      check($sformatf("%s ram[%0h]", nm, v.chk_a[i]), int'(ram[v.chk_a[i]]), int'(v.chk_d[i]));
    end
  endtask

  initial begin
    int dcnt;
    vecs[0] = '{fill:1'b0, src:12'h010, dst:12'h100, len:13'd4, pat:16'h0,
                pre_n:4, pre_a:12'h010, pre_d:{16'h4444, 16'h3333, 16'h2222, 16'h1111},
                poke:-1, exp_k:8, exp_we:4, chk_n:4,
                chk_a:{12'h103, 12'h102, 12'h101, 12'h100},
                chk_d:{16'h4444, 16'h3333, 16'h2222, 16'h1111}};
    vecs[1] = '{fill:1'b1, src:12'h000, dst:12'hFFE, len:13'd4, pat:16'hBEEF,
                pre_n:0, pre_a:12'h0, pre_d:'0,
                poke:-1, exp_k:4, exp_we:4, chk_n:4,
                chk_a:{12'h001, 12'h000, 12'hFFF, 12'hFFE},
                chk_d:{16'hBEEF, 16'hBEEF, 16'hBEEF, 16'hBEEF}};
    vecs[2] = '{fill:1'b0, src:12'h000, dst:12'h001, len:13'd3, pat:16'h0,
                pre_n:4, pre_a:12'h000, pre_d:{16'h0004, 16'h0003, 16'h0002, 16'h0001},
                poke:-1, exp_k:6, exp_we:3, chk_n:4,
                chk_a:{12'h003, 12'h002, 12'h001, 12'h000},
                chk_d:{16'h0001, 16'h0001, 16'h0001, 16'h0001}};
    vecs[3] = '{fill:1'b0, src:12'h020, dst:12'h200, len:13'd0, pat:16'h0,
                pre_n:1, pre_a:12'h200, pre_d:{48'h0, 16'hAAAA},
                poke:-1, exp_k:0, exp_we:0, chk_n:1,
                chk_a:{36'h0, 12'h200}, chk_d:{48'h0, 16'hAAAA}};
    // issued on the first idle edge after the zero-length done
    vecs[4] = '{fill:1'b1, src:12'h000, dst:12'h300, len:13'd1, pat:16'h1234,
                pre_n:0, pre_a:12'h0, pre_d:'0,
                poke:-1, exp_k:1, exp_we:1, chk_n:2,
                chk_a:{24'h0, 12'h301, 12'h300}, chk_d:{32'h0, 16'h0000, 16'h1234}};
    vecs[5] = '{fill:1'b0, src:12'hFFE, dst:12'h020, len:13'd3, pat:16'h0,
                pre_n:0, pre_a:12'h0, pre_d:'0,
                poke:-1, exp_k:6, exp_we:3, chk_n:3,
                chk_a:{12'h0, 12'h022, 12'h021, 12'h020},
                chk_d:{16'h0, 16'h0001, 16'hBEEF, 16'hBEEF}};
    vecs[6] = '{fill:1'b0, src:12'h010, dst:12'h500, len:13'd4, pat:16'h0,
                pre_n:0, pre_a:12'h0, pre_d:'0,
                poke:3, exp_k:8, exp_we:4, chk_n:4,
                chk_a:{12'h600, 12'h503, 12'h501, 12'h500},
                chk_d:{16'h0000, 16'h4444, 16'h2222, 16'h1111}};
    post    = '{fill:1'b1, src:12'h000, dst:12'h700, len:13'd2, pat:16'h1357,
                pre_n:0, pre_a:12'h0, pre_d:'0,
                poke:-1, exp_k:2, exp_we:2, chk_n:4,
                chk_a:{12'h703, 12'h702, 12'h701, 12'h700},
                chk_d:{16'h0000, 16'h7777, 16'h1357, 16'h1357}};

    #2 rst_n = 1'b0;
    #1;
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    check("reset mem_we", int'(mem_we), 0);
    check("reset mem_addr", int'(mem_addr), 0);
    check("reset mem_wdata", int'(mem_wdata), 0);
    for (int a = 0; a < 4096; a++) ram_wr(12'(a), 16'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) apply_vec(vecs[i], $sformatf("v%0d", i));

    // reset in the middle of a fill: three words land, the fourth never does
    @(negedge clk);
    start = 1'b1; fill = 1'b1; dst_addr = 12'h700; length = 13'd8; pattern = 16'h7777;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("midwrite mem_we", int'(mem_we), 1);
    check("midwrite mem_addr", int'(mem_addr), 12'h703);
    rst_n = 1'b0;
    #1;
    check("async_rst mem_we", int'(mem_we), 0);
    check("async_rst busy", int'(busy), 0);
    check("async_rst done", int'(done), 0);
    check("async_rst mem_addr", int'(mem_addr), 0);
    check("async_rst mem_wdata", int'(mem_wdata), 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    rst_n = 1'b1;
    dcnt = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk);
      #1 if (done || busy) dcnt++;
    end
    check("post_reset no done/busy", dcnt, 0);
    apply_vec(post, "post_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_copy_dma.md
# mem_copy_dma

Block-transfer initiator for the 4096 x 16-bit single-port program/data RAM. It drives the RAM's address, write-enable and write-data, and samples its combinational read data. It copies a word range from a source address to a destination address, or fills a range with a constant pattern. It sits beside the multicycle core on the RAM port, behind the existing port mux, and is used for program relocation and memory clearing while the core is stalled.

## Interface
- ADDR_W, 12, RAM address width (RAM depth 2^ADDR_W words)
- DATA_W, 16, RAM word width
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- fill  in  1  0 = copy, 1 = fill with pattern; captured with start
- src_addr  in  ADDR_W  copy source start address; captured with start
- dst_addr  in  ADDR_W  destination start address; captured with start
- length  in  ADDR_W+1  word count, 0..4096; captured with start
- pattern  in  DATA_W  fill value; captured with start
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse at the end of every accepted request
- mem_addr  out  ADDR_W  RAM address
- mem_we  out  1  RAM write enable; a write occurs at the clk edge where this is high
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM combinational read data for mem_addr

## Operation
- The block has four states: IDLE, READ, WRITE and DONE.
- All outputs are functions of the state and internal registers only. There is no combinational path from the inputs to the outputs.
- Internal registers:
  - src_ptr, dst_ptr (ADDR_W bits each)
  - cnt (ADDR_W+1 bits)
  - buf (DATA_W bits)
  - mode
- IDLE:
  - Outputs: busy=0, mem_we=0.
  - On start=1: capture all request inputs. If length==0, go to DONE. Otherwise go to READ if fill=0, or WRITE if fill=1 (buf<=pattern in the fill case).
  - start=0 keeps the block in IDLE.
- READ:
  - mem_addr=src_ptr, mem_we=0.
  - At the edge: buf<=mem_rdata, src_ptr<=src_ptr+1, go to WRITE.
- WRITE:
  - mem_addr=dst_ptr, mem_we=1, mem_wdata=buf.
  - At the edge: dst_ptr<=dst_ptr+1, cnt<=cnt-1.
  - If cnt==1, go to DONE. Otherwise go to READ (copy) or stay in WRITE (fill).
- DONE:
  - Outputs: done=1, busy=1, mem_we=0.
  - Always go to IDLE on the next edge.
- Pointer arithmetic is modulo 2^ADDR_W. An address of 4095 plus 1 wraps to 0, and a transfer that crosses the top of memory continues from address 0.
- Copy is strictly ascending and word-by-word. With overlapping ranges where dst > src, already-written words are re-read. This result is the defined behaviour, not an error.
- length=4096 transfers the whole memory.
- start asserted while busy=1 is ignored and is not queued.
- When idle (and in READ/DONE where not specified above), mem_addr=0 and mem_wdata=0.
- Reset:
  - rst_n=0 forces IDLE immediately, regardless of clk.
  - All registers clear to 0, and busy=0, done=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - A reset mid-transfer abandons the transfer. No done pulse is produced, and words already written stay written.

## Timing
- start is sampled at edge E0.
- Copy of N≥1 words:
  - READ of word i occupies cycle E0+2i .. E0+2i+1, for i=0..N-1.
  - The write of word i lands at edge E0+2i+2.
  - done is high during cycle E0+2N .. E0+2N+1.
  - busy falls after edge E0+2N+1.
- Fill of N words:
  - The write of word i lands at edge E0+i+1.
  - done is high for the cycle following edge E0+N.
- length=0: done is high for the cycle after E0, and no RAM access occurs.
- Back-to-back requests: a new start is accepted at the first edge where the state is IDLE, which is one cycle after done.
- The source read must settle within one clk period. The RAM read is combinational, so mem_rdata is valid in the same cycle as mem_addr.

## Test plan
- Copy: preload RAM[0x010..0x013] with 0x1111, 0x2222, 0x3333, 0x4444, then start src=0x010, dst=0x100, length=4 -> RAM[0x100..0x103] holds the same values. mem_we pulses exactly 4 times. done is one cycle, 8 cycles after the start edge.
- Fill with wrap: fill=1, dst=0xFFE, length=4, pattern=0xBEEF -> RAM[0xFFE], RAM[0xFFF], RAM[0x000] and RAM[0x001] all read 0xBEEF. Four consecutive write cycles occur.
- Zero length: length=0 -> no mem_we, and done is asserted in the cycle after start. Then a start issued immediately after done is accepted.
- Overlap: RAM[0..3]=1,2,3,4, then copy src=0, dst=1, length=3 -> RAM[0..3]=1,1,1,1.
- Busy ignore plus reset: pulse start again mid-transfer, and confirm there is no effect. Then drive rst_n low mid-write -> mem_we, busy and done go to 0 immediately. No done pulse appears. The next request completes normally.
